us_alarm: RTL and testbench
===========================

// Module: us_alarm
// PURPOSE
//  Programmable microsecond alarm driven by the free-running timebase `us` count.
//  Software/FSM arms an absolute or relative deadline, optionally periodic; block
//  emits a one-cycle `fire` pulse on expiry and counts missed periods.
//  Wrap-safe across the 32-bit counter rollover; sits beside the timebase in clock lib.
// PARAMETERS
//  W         32   width of time values; must equal timebase counter width
//  MISS_W    8    width of saturating missed-period counter
// PORTS
//  clk         in   1       system clock, single clock domain
//  rst_n       in   1       asynchronous, active-low reset
//  now_us      in   W       current time from timebase, monotonic +1 steps, wraps
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       block can accept command this cycle
//  cmd_op      in   2       0 NOP, 1 ARM_ABS, 2 ARM_REL, 3 CANCEL
//  cmd_time    in   W       ABS: deadline; REL: offset added to now_us
//  cmd_period  in   W       reload interval; 0 = one-shot; must be < 2**(W-1)
//  fire        out  1       registered one-cycle pulse per expiry
//  armed       out  1       1 in ARMED or RELOAD
//  deadline    out  W       current target time
//  missed      out  MISS_W  periods skipped during catch-up, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, fire=0, armed=0, deadline=0, missed=0,
//    period reg=0; cmd_ready=1 on first cycle after release. Mid-operation reset aborts all.
//  - Expiry test: expired = MSB of (now_us - deadline) == 0, i.e. signed diff >= 0, mod 2**W.
//    Deadlines must lie within 2**(W-1) of now_us; past deadline fires at once.
//  - Handshake: accept on cmd_valid & cmd_ready; cmd_ready=1 in IDLE/ARMED, 0 in RELOAD.
//  - ARM_ABS: deadline<=cmd_time; ARM_REL: deadline<=now_us+cmd_time (mod 2**W);
//    both: period<=cmd_period, missed<=0, -> ARMED. Re-arm while ARMED replaces deadline.
//  - CANCEL: -> IDLE, armed=0, deadline held. NOP / CANCEL in IDLE: no effect.
//  - States: IDLE, ARMED, RELOAD.
//    ARMED & expired & no accepted cmd: fire=1 next cycle; if period==0 -> IDLE,
//      else deadline<=deadline+period, -> RELOAD.
//    RELOAD: if new deadline still expired: deadline+=period, missed++ (sat at max), stay;
//      else -> ARMED. One addition per cycle; no fire pulses in RELOAD.
//  - Latency: fire asserts cycle N+1 when now_us sampled expired at edge N.
//    ARM_REL with cmd_time=0 accepted at edge N: fire at N+2.
//  - Simultaneous accepted command and expiry: command wins, that fire suppressed.
//  - fire never asserted two consecutive cycles; fire count = periods elapsed - missed.
//  - Wrap: deadline/now arithmetic purely modular; no special case at 0xFFFF_FFFF -> 0.
// STRUCTURE
//  - Package us_alarm_pkg: OP_NOP/OP_ARM_ABS/OP_ARM_REL/OP_CANCEL encodings, state
//    encoding (ST_IDLE, ST_ARMED, ST_RELOAD).
//  - Sub-module us_expired: combinational wrap-aware compare (now, deadline) -> expired;
//    reused by future timer-compare blocks.
//  - Top: FSM, deadline/period/missed regs, registered fire.
// TESTING
//  - ARM_REL time=5 at now=100 -> deadline=105; fire one cycle after now_us=105 sampled; IDLE.
//  - ARM_ABS time=0x0000_0003 at now=0xFFFF_FFFE -> no fire across wrap until now=3; one pulse.
//  - Periodic: ARM_REL time=10 period=10 at now=0 -> fires after 10,20,30; missed stays 0.
//  - Catch-up: periodic period=2, hold now_us then jump +7 -> one fire, RELOAD 3 cycles,
//    missed=3, cmd_ready=0 during RELOAD, then ARMED with deadline > now.
//  - CANCEL in same cycle as expiry -> no fire, armed=0; ARM_ABS past time -> immediate fire.
//  - rst_n low mid-RELOAD -> all outputs zero asynchronously; after release cmd_ready=1, no fire.

Source files
------------

// File: rtl/us_alarm_pkg.sv
// us_alarm_pkg: command opcodes and FSM state encoding for the microsecond alarm
package us_alarm_pkg;
    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_ARM_ABS = 2'd1,
        OP_ARM_REL = 2'd2,
        OP_CANCEL  = 2'd3
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RELOAD = 2'd2
    } state_e;
endpackage

// File: rtl/us_expired.sv
// us_expired: wrap-aware compare, expired when (now - deadline) is non-negative mod 2**W
module us_expired #(
    parameter int W = 32
) (
    input  logic [W-1:0] now,
    input  logic [W-1:0] deadline,
    output logic         expired
);
    assign expired = $signed(now - deadline) >= 0;
endmodule

// File: rtl/us_alarm.sv
// us_alarm: programmable one-shot/periodic microsecond alarm with missed-period catch-up
module us_alarm
    import us_alarm_pkg::*;
#(
    parameter int W      = 32,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      now_us,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [W-1:0]      cmd_time,
    input  logic [W-1:0]      cmd_period,
    output logic              fire,
    output logic              armed,
    output logic [W-1:0]      deadline,
    output logic [MISS_W-1:0] missed
);
    state_e             state, state_n;
    logic [W-1:0]       deadline_n, period, period_n;
    logic [MISS_W-1:0]  missed_n;
    logic               fire_n, expired, accept, arm, cancel;

    us_expired #(.W(W)) u_expired (
        .now      (now_us),
        .deadline (deadline),
        .expired  (expired)
    );

    assign cmd_ready = state != ST_RELOAD;
    assign armed     = state != ST_IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign arm       = accept && (cmd_op == OP_ARM_ABS || cmd_op == OP_ARM_REL);
    assign cancel    = accept && cmd_op == OP_CANCEL;

    // An accepted command always takes priority over a coincident expiry
    always_comb begin
        state_n    = state;
        deadline_n = deadline;
        period_n   = period;
        missed_n   = missed;
        fire_n     = 1'b0;
        if (arm) begin
            deadline_n = (cmd_op == OP_ARM_REL) ? now_us + cmd_time : cmd_time;
            period_n   = cmd_period;
            missed_n   = '0;
            state_n    = ST_ARMED;
        end else if (cancel) begin
            state_n = ST_IDLE;
        end else if (state == ST_ARMED && expired) begin
            fire_n     = 1'b1;
            deadline_n = deadline + period;
            state_n    = (period == '0) ? ST_IDLE : ST_RELOAD;
        end else if (state == ST_RELOAD) begin
            deadline_n = expired ? deadline + period : deadline;
            missed_n   = (expired && !(&missed)) ? missed + 1'b1 : missed;
            state_n    = expired ? ST_RELOAD : ST_ARMED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            deadline <= '0;
            period   <= '0;
            missed   <= '0;
            fire     <= 1'b0;
        end else begin
            state    <= state_n;
            deadline <= deadline_n;
            period   <= period_n;
            missed   <= missed_n;
            fire     <= fire_n;
        end
    end
endmodule

// File: tb/tb_us_alarm.sv
// tb_us_alarm: directed-vector bench for us_alarm with hand-computed expectations
module tb_us_alarm;
    import us_alarm_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, fire, armed;
    logic [1:0]  cmd_op;
    logic [31:0] now_us, cmd_time, cmd_period, deadline;
    logic [7:0]  missed;
    int          pass_cnt = 0, total = 0, fire_cnt = 0, f0;

    us_alarm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .now_us     (now_us),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_time   (cmd_time),
        .cmd_period (cmd_period),
        .fire       (fire),
        .armed      (armed),
        .deadline   (deadline),
        .missed     (missed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) fire_cnt <= fire_cnt + int'(fire === 1'b1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] t);
        now_us = t;
        tick();
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] t, input logic [31:0] p);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_time   = t;
        cmd_period = p;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; now_us = 0; cmd_time = 0; cmd_period = 0;
        #3;
        total++; if ({fire, armed, deadline, missed} !== 42'd0) $display("FAIL reset_outs got=%h exp=0", {fire, armed, deadline, missed}); else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready); else pass_cnt++;
        total++; if ({fire, armed} !== 2'b00) $display("FAIL reset_idle fire/armed got=%b exp=00", {fire, armed}); else pass_cnt++;
    endtask

    task automatic test_rel_oneshot();
        now_us = 100;
        cmd(OP_ARM_REL, 5, 0);
        total++; if (armed !== 1'b1) $display("FAIL rel_armed got=%b exp=1", armed); else pass_cnt++;
        total++; if (deadline !== 32'd105) $display("FAIL rel_deadline got=%0d exp=105", deadline); else pass_cnt++;
        for (int t = 101; t < 105; t++) begin
            step(t);
            total++; if (fire !== 1'b0) $display("FAIL rel_early now=%0d got=%b exp=0", t, fire); else pass_cnt++;
        end
        step(105);
        total++; if (fire !== 1'b1) $display("FAIL rel_fire got=%b exp=1", fire); else pass_cnt++;
        total++; if (armed !== 1'b0) $display("FAIL rel_idle armed got=%b exp=0", armed); else pass_cnt++;
        step(106);
        total++; if (fire !== 1'b0) $display("FAIL rel_pulse got=%b exp=0", fire); else pass_cnt++;
    endtask

    task automatic test_wrap();
        now_us = 32'hFFFF_FFFE;
        cmd(OP_ARM_ABS, 3, 0);
        f0 = fire_cnt;
        for (int i = 1; i < 5; i++) begin
            step(32'hFFFF_FFFE + 32'(i));
            total++; if (fire !== 1'b0) $display("FAIL wrap_early now=%h got=%b exp=0", now_us, fire); else pass_cnt++;
        end
        step(3);
        total++; if (fire !== 1'b1) $display("FAIL wrap_fire got=%b exp=1", fire); else pass_cnt++;
        step(4);
        total++; if (fire_cnt - f0 !== 1) $display("FAIL wrap_count got=%0d exp=1", fire_cnt - f0); else pass_cnt++;
    endtask

    task automatic test_periodic();
        now_us = 0;
        cmd(OP_ARM_REL, 10, 10);
        f0 = fire_cnt;
        for (int t = 1; t < 36; t++) begin
            step(t);
            total++; if (fire !== (t % 10 == 0)) $display("FAIL periodic_fire now=%0d got=%b exp=%b", t, fire, t % 10 == 0); else pass_cnt++;
        end
        total++; if (missed !== 8'd0) $display("FAIL periodic_missed got=%0d exp=0", missed); else pass_cnt++;
        total++; if (deadline !== 32'd40) $display("FAIL periodic_deadline got=%0d exp=40", deadline); else pass_cnt++;
        total++; if (fire_cnt - f0 !== 3) $display("FAIL periodic_count got=%0d exp=3", fire_cnt - f0); else pass_cnt++;
        cmd(OP_CANCEL, 0, 0);
        total++; if (armed !== 1'b0) $display("FAIL cancel_armed got=%b exp=0", armed); else pass_cnt++;
        total++; if (deadline !== 32'd40) $display("FAIL cancel_hold got=%0d exp=40", deadline); else pass_cnt++;
    endtask

    task automatic test_catchup();
        now_us = 50;
        cmd(OP_ARM_REL, 2, 2);
        step(51);
        step(51);
        total++; if (fire !== 1'b0) $display("FAIL catch_early got=%b exp=0", fire); else pass_cnt++;
        f0 = fire_cnt;
        step(58);
        total++; if (fire !== 1'b1) $display("FAIL catch_fire got=%b exp=1", fire); else pass_cnt++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL catch_ready0 got=%b exp=0", cmd_ready); else pass_cnt++;
        total++; if (deadline !== 32'd54) $display("FAIL catch_dl0 got=%0d exp=54", deadline); else pass_cnt++;
        cmd_valid = 1'b1;
        cmd_op    = OP_CANCEL;
        for (int i = 1; i < 4; i++) begin
            tick();
            total++; if ({cmd_ready, fire} !== 2'b00) $display("FAIL catch_reload i=%0d ready/fire got=%b exp=00", i, {cmd_ready, fire}); else pass_cnt++;
            total++; if (missed !== 8'(i)) $display("FAIL catch_missed i=%0d got=%0d exp=%0d", i, missed, i); else pass_cnt++;
        end
        cmd_valid = 1'b0;
        tick();
        total++; if ({cmd_ready, armed} !== 2'b11) $display("FAIL catch_armed ready/armed got=%b exp=11", {cmd_ready, armed}); else pass_cnt++;
        total++; if (missed !== 8'd3) $display("FAIL catch_missed_final got=%0d exp=3", missed); else pass_cnt++;
        total++; if (deadline !== 32'd60) $display("FAIL catch_dl_final got=%0d exp=60", deadline); else pass_cnt++;
        total++; if (fire_cnt - f0 !== 1) $display("FAIL catch_count got=%0d exp=1", fire_cnt - f0); else pass_cnt++;
        cmd(OP_CANCEL, 0, 0);
    endtask

    task automatic test_cancel_expiry();
        now_us = 200;
        cmd(OP_ARM_ABS, 500, 0);
        cmd(OP_ARM_ABS, 205, 0);
        total++; if (deadline !== 32'd205) $display("FAIL rearm_deadline got=%0d exp=205", deadline); else pass_cnt++;
        for (int t = 201; t < 205; t++) step(t);
        now_us = 205;
        cmd(OP_CANCEL, 0, 0);
        total++; if ({fire, armed} !== 2'b00) $display("FAIL cancel_expiry fire/armed got=%b exp=00", {fire, armed}); else pass_cnt++;
        step(206);
        total++; if (fire !== 1'b0) $display("FAIL cancel_nofire got=%b exp=0", fire); else pass_cnt++;
    endtask

    task automatic test_immediate();
        now_us = 300;
        cmd(OP_ARM_ABS, 290, 0);
        total++; if ({fire, armed} !== 2'b01) $display("FAIL past_arm fire/armed got=%b exp=01", {fire, armed}); else pass_cnt++;
        step(301);
        total++; if ({fire, armed} !== 2'b10) $display("FAIL past_fire fire/armed got=%b exp=10", {fire, armed}); else pass_cnt++;
        step(302);
        total++; if (fire !== 1'b0) $display("FAIL past_pulse got=%b exp=0", fire); else pass_cnt++;
        now_us = 400;
        cmd(OP_ARM_REL, 0, 0);
        total++; if (fire !== 1'b0 || deadline !== 32'd400) $display("FAIL rel0_arm fire=%b dl=%0d exp 0/400", fire, deadline); else pass_cnt++;
        step(401);
        total++; if (fire !== 1'b1) $display("FAIL rel0_fire got=%b exp=1", fire); else pass_cnt++;
        step(402);
    endtask

    task automatic test_reset_mid_reload();
        now_us = 600;
        cmd(OP_ARM_REL, 2, 2);
        step(610);
        total++; if ({fire, cmd_ready} !== 2'b10) $display("FAIL mid_fire fire/ready got=%b exp=10", {fire, cmd_ready}); else pass_cnt++;
        tick();
        total++; if (missed !== 8'd1) $display("FAIL mid_missed got=%0d exp=1", missed); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({fire, armed, deadline, missed} !== 42'd0) $display("FAIL mid_reset_outs got=%h exp=0", {fire, armed, deadline, missed}); else pass_cnt++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL mid_reset_ready got=%b exp=1", cmd_ready); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        for (int t = 611; t < 615; t++) begin
            step(t);
            total++; if ({fire, armed, cmd_ready} !== 3'b001) $display("FAIL post_reset now=%0d fire/armed/ready got=%b exp=001", t, {fire, armed, cmd_ready}); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_rel_oneshot();
        test_wrap();
        test_periodic();
        test_catchup();
        test_cancel_expiry();
        test_immediate();
        test_reset_mid_reload();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
